// File: rtl/gobang_pkg.sv
// Shared gobang constants: board geometry, cell and direction
// encodings, and the win checker state type.
package gobang_pkg;

    localparam int BOARD_SIZE = 15;
    localparam int WIN_LEN    = 5;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;

    localparam logic [1:0] DIR_H = 2'd0;
    localparam logic [1:0] DIR_V = 2'd1;
    localparam logic [1:0] DIR_D = 2'd2;
    localparam logic [1:0] DIR_A = 2'd3;

    localparam logic HALF_POS = 1'b0;
    localparam logic HALF_NEG = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_CMP,
        S_DONE
    } state_t;

endpackage

// File: rtl/board_addr_gen.sv
// Probe cell generator: origin +/- (step+1)*delta(dir), bounds check
// and row-major RAM address.
module board_addr_gen
    import gobang_pkg::*;
#(
    parameter int BOARD_SIZE = gobang_pkg::BOARD_SIZE
) (
    input  logic [3:0] org_x,
    input  logic [3:0] org_y,
    input  logic [1:0] dir,
    input  logic       half,
    input  logic [2:0] step,
    output logic [3:0] nx,
    output logic [3:0] ny,
    output logic       in_bounds,
    output logic [7:0] rd_addr
);

    localparam logic signed [4:0] BS = 5'(BOARD_SIZE);

    logic signed [4:0] dx, dy, off, sx, sy;

    always_comb begin
        dx = 5'sd0;
        dy = 5'sd0;
        case (dir)
            DIR_H:   dx = 5'sd1;
            DIR_V:   dy = 5'sd1;
            DIR_D:   begin dx = 5'sd1; dy = 5'sd1;  end
            default: begin dx = 5'sd1; dy = -5'sd1; end
        endcase
        if (half == HALF_NEG) begin
            dx = -dx;
            dy = -dy;
        end
    end

    // Sums past +15 wrap to negative here and are rejected by the sign test.
    assign off = $signed({2'b00, step}) + 5'sd1;
    assign sx  = $signed({1'b0, org_x}) + dx * off;
    assign sy  = $signed({1'b0, org_y}) + dy * off;

    assign in_bounds = !sx[4] && (sx < BS) && !sy[4] && (sy < BS);
    assign nx        = sx[3:0];
    assign ny        = sy[3:0];
    assign rd_addr   = 8'(ny) * 8'(BOARD_SIZE) + 8'(nx);

endmodule

// File: rtl/win_checker.sv
// Five-in-a-row detector: walks the four lines through the placed
// stone, reading the board RAM one cell at a time.
module win_checker
    import gobang_pkg::*;
#(
    parameter int BOARD_SIZE = gobang_pkg::BOARD_SIZE,
    parameter int WIN_LEN    = gobang_pkg::WIN_LEN
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [1:0] player,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win
);

    localparam logic [2:0] WL   = 3'(WIN_LEN);
    localparam logic [2:0] WL_1 = 3'(WIN_LEN - 1);

    state_t     state, state_n;
    logic [3:0] ox, oy, ox_n, oy_n;
    logic [1:0] ply, ply_n;
    logic [1:0] dir, dir_n;
    logic       half, half_n;
    logic [2:0] count, count_n;
    logic [2:0] step, step_n;
    logic       win_n;
    logic [7:0] addr_q;

    logic       in_b;
    logic [7:0] gen_addr;
    logic [3:0] unused_nx, unused_ny;
    logic       bad_start;
    logic       end_half;

    board_addr_gen #(.BOARD_SIZE(BOARD_SIZE)) u_gen (
        .org_x     (ox),
        .org_y     (oy),
        .dir       (dir),
        .half      (half),
        .step      (step),
        .nx        (unused_nx),
        .ny        (unused_ny),
        .in_bounds (in_b),
        .rd_addr   (gen_addr)
    );

    assign bad_start = ({1'b0, x} >= 5'(BOARD_SIZE))
                    || ({1'b0, y} >= 5'(BOARD_SIZE))
                    || !(player == CELL_BLACK || player == CELL_WHITE);

    assign rd_en   = (state == S_STEP) && in_b;
    assign rd_addr = rd_en ? gen_addr : addr_q;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_comb begin
        state_n  = state;
        ox_n     = ox;
        oy_n     = oy;
        ply_n    = ply;
        dir_n    = dir;
        half_n   = half;
        count_n  = count;
        step_n   = step;
        win_n    = win;
        end_half = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    ox_n    = x;
                    oy_n    = y;
                    ply_n   = player;
                    win_n   = 1'b0;
                    dir_n   = DIR_H;
                    half_n  = HALF_POS;
                    count_n = 3'd1;
                    step_n  = 3'd0;
                    state_n = bad_start ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                if (in_b) state_n = S_CMP;
                else      end_half = 1'b1;
            end
            S_CMP: begin
                if (rd_data == ply) begin
                    count_n = count + 3'd1;
                    step_n  = step + 3'd1;
                    if (count_n == WL) begin
                        win_n   = 1'b1;
                        state_n = S_DONE;
                    end else if (step_n == WL_1) begin
                        end_half = 1'b1;
                    end else begin
                        state_n = S_STEP;
                    end
                end else begin
                    end_half = 1'b1;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        // Finishing a half is resolved in the same cycle; no extra state.
        if (end_half) begin
            step_n  = 3'd0;
            state_n = S_STEP;
            if (half == HALF_POS) begin
                half_n = HALF_NEG;
            end else if (dir == DIR_A) begin
                state_n = S_DONE;
            end else begin
                dir_n   = dir + 2'd1;
                half_n  = HALF_POS;
                count_n = 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            ox     <= '0;
            oy     <= '0;
            ply    <= '0;
            dir    <= DIR_H;
            half   <= HALF_POS;
            count  <= '0;
            step   <= '0;
            win    <= 1'b0;
            addr_q <= '0;
        end else begin
            state <= state_n;
            ox    <= ox_n;
            oy    <= oy_n;
            ply   <= ply_n;
            dir   <= dir_n;
            half  <= half_n;
            count <= count_n;
            step  <= step_n;
            win   <= win_n;
            if (rd_en) addr_q <= gen_addr;
        end
    end

endmodule

// File: tb/tb_win_checker.sv
// Scoreboard bench for win_checker: directed scans against a
// behavioural board RAM with one-cycle read latency.
module tb_win_checker;
    import gobang_pkg::*;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [1:0] player = '0;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [1:0] rd_data = '0;
    logic       busy, done, win;

    always #10 clock = ~clock;

    win_checker dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .x       (x),
        .y       (y),
        .player  (player),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .win     (win)
    );

    logic [1:0] board [0:224];

    always @(posedge clock)
        if (rd_en) rd_data <= (rd_addr < 8'd225) ? board[rd_addr] : 2'b11;

    typedef struct {
        logic  w;
        int    cyc;
        int    reads;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 225; i++) board[i] = CELL_EMPTY;
    endtask

    task automatic put(input int cx, input int cy, input logic [1:0] v);
        board[cy * 15 + cx] = v;
    endtask

    // Monitor: counts cycles and reads of each scan, checks on done.
    initial begin : mon
        int   cyc;
        int   reads;
        bit   was_busy;
        bit   prev_rd;
        exp_t e;
        cyc = 0; reads = 0; was_busy = 0; prev_rd = 0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                was_busy = 0;
                prev_rd  = 0;
            end else begin
                if (busy && !was_busy) begin
                    cyc   = 0;
                    reads = 0;
                end
                if (busy) cyc++;
                was_busy = busy;
                if (rd_en) begin
                    reads++;
                    if (rd_addr >= 8'd225) chk("addr_range", rd_addr, 0);
                    if (prev_rd) chk("rd_en_back_to_back", 1, 0);
                end
                prev_rd = rd_en;
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_win"}, win, e.w);
                        chk({e.name, "_done_cycle"}, cyc, e.cyc);
                        chk({e.name, "_reads"}, reads, e.reads);
                    end
                end
            end
        end
    end

    task automatic scan(input int sx, input int sy, input logic [1:0] p,
                        input logic w, input int c, input int r,
                        input string nm, input int glitch_at);
        exp_t e;
        @(negedge clock);
        x      = 4'(sx);
        y      = 4'(sy);
        player = p;
        start  = 1'b1;
        e.w = w; e.cyc = c; e.reads = r; e.name = nm;
        sb.push_back(e);
        @(negedge clock);
        start  = 1'b0;
        x      = 4'd0;
        y      = 4'd0;
        player = 2'b00;
        for (int i = 1; i < 200 && sb.size() != 0; i++) begin
            if (i == glitch_at) begin
                x = 4'd2; y = 4'd2; player = CELL_WHITE; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            chk({nm, "_timeout"}, 1, 0);
            sb.delete();
        end
    endtask

    initial begin
        clear_board();
        #15;
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_win", win, 0);
        @(negedge clock);
        resetn = 1'b1;

        scan(7, 7, CELL_BLACK, 1'b0, 17, 8, "empty_center", 0);
        chk("rd_addr_hold", rd_addr, 8 * 15 + 6);

        for (int i = 3; i <= 6; i++) put(i, 7, CELL_BLACK);
        scan(7, 7, CELL_BLACK, 1'b1, 11, 5, "h_neg_win", 0);
        repeat (3) @(negedge clock);
        chk("win_held", win, 1);

        clear_board();
        scan(0, 0, CELL_BLACK, 1'b0, 12, 3, "corner", 0);

        put(10, 4, CELL_WHITE);
        put(11, 3, CELL_WHITE);
        put(12, 2, CELL_WHITE);
        put(13, 1, CELL_WHITE);
        scan(9, 5, CELL_WHITE, 1'b1, 21, 10, "anti_diag_win", 0);
        put(12, 2, CELL_BLACK);
        scan(9, 5, CELL_WHITE, 1'b0, 21, 10, "anti_diag_broken", 0);

        clear_board();
        scan(15, 3, CELL_BLACK, 1'b0, 1, 0, "x_out_of_range", 0);
        scan(7, 7, 2'b00, 1'b0, 1, 0, "bad_player", 0);
        scan(7, 7, CELL_WHITE, 1'b0, 17, 8, "start_mid_scan", 3);
        repeat (20) @(negedge clock);

        // Abort a scan with reset in its fifth cycle.
        @(negedge clock);
        x = 4'd7; y = 4'd7; player = CELL_BLACK; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk("busy_before_reset", busy, 1);
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_done", done, 0);
        chk("abort_win", win, 0);
        @(negedge clock);
        resetn = 1'b1;
        scan(7, 7, CELL_BLACK, 1'b0, 17, 8, "after_reset", 0);

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
